// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows byte permutation, one registered stage with
// valid/ready handshake on both sides.
module shift_rows #(
  parameter int SUPPORT_INV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] matrix_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] matrix_out
);

  // Byte k of the state lives at bits [127-8k -: 8]; s[r][c] = byte r+4c.
  // Row r takes its byte for column c from column c+r (forward) or c-r (inverse).
  function automatic logic [127:0] permute(input logic [127:0] s, input logic inv_sel);
    logic [127:0] o;
    logic [1:0]   src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv_sel ? 2'(c - r) : 2'(c + r);
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*int'(src)) -: 8];
      end
    end
    return o;
  endfunction

  logic inv_eff;
  logic accept;

  assign inv_eff  = (SUPPORT_INV != 0) && inv;
  // Ready depends only on registered state and out_ready, so there is no
  // combinational path from the input side to the output side.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      matrix_out <= '0;
    end else if (accept) begin
      matrix_out <= permute(matrix_in, inv_eff);
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      // Drain: data holds its last value, only the valid flag drops.
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_rows.sv
// Directed self-checking bench for shift_rows: FIPS-197 vectors, backpressure,
// async reset, and a streaming run against a row-rotation reference model.
module tb_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [127:0] matrix_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] matrix_out;

  logic         f_in_ready;
  logic         f_out_valid;
  logic [127:0] f_matrix_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] VEC_A   = 128'hd4e0b81e27bfb44111985d52aef1e530;
  localparam logic [127:0] FWD_A   = 128'hd4bf5d302798e51e11f1b841aee0b452;
  localparam logic [127:0] INV_A   = 128'hd4f15d4127e0e55211bfb830ae98b41e;
  localparam logic [127:0] VEC_ID  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FWD_ID  = 128'h00050a0f04090e03080d02070c01060b;

  shift_rows #(.SUPPORT_INV(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inv(inv), .matrix_in(matrix_in), .out_valid(out_valid),
    .out_ready(out_ready), .matrix_out(matrix_out)
  );

  shift_rows #(.SUPPORT_INV(0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .inv(inv), .matrix_in(matrix_in), .out_valid(f_out_valid),
    .out_ready(out_ready), .matrix_out(f_matrix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: gather each row as a 32-bit word (column 0 in the MSB) and
  // rotate it as a whole, then scatter it back.
  function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic inv_sel);
    logic [127:0] o;
    logic [31:0]  w;
    logic [63:0]  ww;
    logic [31:0]  rot;
    int           start;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) w[31 - 8*c -: 8] = s[127 - 8*(r + 4*c) -: 8];
      ww    = {w, w};
      start = inv_sel ? ((4 - r) % 4) : r;
      rot   = ww[63 - 8*start -: 32];
      for (int c = 0; c < 4; c++) o[127 - 8*(r + 4*c) -: 8] = rot[31 - 8*c -: 8];
    end
    return o;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] st;
    logic         iv;

    rst_n = 1'b0; in_valid = 1'b0; inv = 1'b0; matrix_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_matrix_out", matrix_out, '0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back transactions with alternating inv.
    in_valid = 1'b1; inv = 1'b0; matrix_in = VEC_A;
    tick();
    check("fwd_valid", 128'(out_valid), 128'(1));
    check("fwd_fips", matrix_out, FWD_A);

    inv = 1'b1;
    tick();
    check("inv_fips", matrix_out, INV_A);
    check("noinv_param_fwd", f_matrix_out, FWD_A);

    matrix_in = FWD_A;
    tick();
    check("round_trip", matrix_out, VEC_A);

    inv = 1'b0; matrix_in = VEC_ID;
    tick();
    check("identity_fwd", matrix_out, FWD_ID);

    // Drain: valid drops, data holds.
    in_valid = 1'b0; matrix_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    tick();
    check("drain_valid", 128'(out_valid), 128'(0));
    check("drain_hold", matrix_out, FWD_ID);

    // Backpressure: accept with out_ready low, then stall three cycles.
    in_valid = 1'b1; inv = 1'b0; matrix_in = VEC_A; out_ready = 1'b0;
    #1;
    check("empty_ready_bp", 128'(in_ready), 128'(1));
    tick();
    check("bp_load", matrix_out, FWD_A);
    matrix_in = VEC_ID;
    #1;
    check("stall_in_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data", matrix_out, FWD_A);
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 128'(in_ready), 128'(1));
    tick();
    check("release_load", matrix_out, FWD_ID);
    check("release_valid", 128'(out_valid), 128'(1));

    // Reset asserted mid-stall, between clock edges.
    out_ready = 1'b0; matrix_in = VEC_A; inv = 1'b1;
    tick();
    check("stall2_hold", matrix_out, FWD_ID);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'(0));
    check("async_rst_data", matrix_out, '0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_idle", 128'(out_valid), 128'(0));
    end

    // Streaming: one random state per cycle with mixed inv.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      iv = 1'($urandom_range(0, 1));
      matrix_in = st; inv = iv;
      tick();
      check($sformatf("stream_%0d", i), matrix_out, ref_perm(st, iv));
      check($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'(1));
      check($sformatf("stream_fwdonly_%0d", i), f_matrix_out, ref_perm(st, 1'b0));
    end
    in_valid = 1'b0;
    tick();
    check("final_drain", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
